// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// controller states and the default bus address.
package irq_controller_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0030;

  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_EN    = 4'h4;
  localparam logic [3:0] OFF_CAUSE = 4'h8;
  localparam logic [3:0] OFF_CTRL  = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POSTED  = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Memory-mapped bus shared by DataMem, Peripheral and the interrupt controller.
interface irq_controller_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 has the highest priority.
module irq_prio_enc #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = 3'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches source edges, applies enables and fixed
// priority, and posts one registered IRQ at a time against CPU kernel mode.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             kernel,
  irq_controller_if.slave  bus,
  output logic             irqout
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] en;
  logic             gie;
  logic [2:0]       cause;
  state_t           state, state_n;
  logic [2:0]       cause_n;
  logic             irq_n;
  logic             take;

  logic [N_SRC-1:0] ev;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] set_v;
  logic [N_SRC-1:0] clr_v;
  logic [2:0]       win;
  logic             win_valid;

  logic             sel;
  logic [3:0]       off;
  logic             wr_pend, wr_en, wr_ctrl;
  logic [31:0]      rdata;
  logic             unused_wdata;

  assign sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off     = bus.addr[3:0];
  assign wr_pend = bus.wr && sel && (off == OFF_PEND);
  assign wr_en   = bus.wr && sel && (off == OFF_EN);
  assign wr_ctrl = bus.wr && sel && (off == OFF_CTRL);
  assign unused_wdata = ^bus.wdata[31:N_SRC];

  assign ev  = src & ~src_q;
  assign req = pend & en;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req   (req),
    .idx   (win),
    .valid (win_valid)
  );

  // Sets are OR-ed in after clears so an event coinciding with a W1C or a
  // take of the same bit is kept pending.
  always_comb begin
    set_v = ev;
    if (wr_ctrl && bus.wdata[1]) set_v[N_SRC-1] = 1'b1;
    clr_v = take ? (N_SRC'(1) << win) : '0;
    if (wr_pend) clr_v = clr_v | bus.wdata[N_SRC-1:0];
  end

  always_comb begin
    state_n = state;
    cause_n = cause;
    irq_n   = irqout;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (gie && win_valid && !kernel) begin
          take    = 1'b1;
          cause_n = win;
          irq_n   = 1'b1;
          state_n = POSTED;
        end
      end
      POSTED: begin
        if (kernel) begin
          irq_n   = 1'b0;
          state_n = SERVICE;
        end
      end
      SERVICE: begin
        // Entered only after kernel=1 was sampled, so kernel=0 here is the return.
        irq_n = 1'b0;
        if (!kernel) state_n = IDLE;
      end
      default: begin
        irq_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q  <= '0;
      pend   <= '0;
      en     <= '0;
      gie    <= 1'b0;
      cause  <= '0;
      irqout <= 1'b0;
      state  <= IDLE;
    end else begin
      src_q  <= src;
      pend   <= (pend & ~clr_v) | set_v;
      cause  <= cause_n;
      irqout <= irq_n;
      state  <= state_n;
      if (wr_en)   en  <= bus.wdata[N_SRC-1:0];
      if (wr_ctrl) gie <= bus.wdata[0];
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.rd && sel) begin
      case (off)
        OFF_PEND:  rdata[N_SRC-1:0] = pend;
        OFF_EN:    rdata[N_SRC-1:0] = en;
        OFF_CAUSE: rdata = {(state != IDLE), 28'b0, cause};
        OFF_CTRL:  rdata[0] = gie;
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.rdata = rdata;

endmodule
